// File: rtl/pll_reset_seq.sv
// Downstream reset sequencer: qualifies a PLL lock, holds reset for a fixed time,
// then releases it, re-asserting on lock loss or on a soft reset request.
module pll_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int RESET_HOLD_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       soft_reset,
  output logic       rst_out,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    STABLE    = 2'b01,
    HOLD      = 2'b10,
    RUN       = 2'b11
  } state_t;

  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(RESET_HOLD_CYCLES - 1);

  state_t      cur_state;
  logic        locked_meta;
  logic        locked_s;
  logic [15:0] cycle_cnt;

  // Two-flop synchronizer; locked comes from the PLL and is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= locked;
      locked_s    <= locked_meta;
    end
  end

  // ready is a status flag, not a handshake: it mirrors RUN and carries no transfer.
  // rst_out and ready are updated on the same edge as every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state     <= WAIT_LOCK;
      cycle_cnt     <= 16'd0;
      rst_out       <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      case (cur_state)
        WAIT_LOCK: begin
          if (locked_s) begin
            cur_state <= STABLE;
            cycle_cnt <= 16'd0;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            cur_state <= WAIT_LOCK;
            cycle_cnt <= 16'd0;
          end else if (cycle_cnt == STABLE_LAST) begin
            cur_state <= HOLD;
            cycle_cnt <= 16'd0;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (!locked_s) begin
            cur_state <= WAIT_LOCK;
            cycle_cnt <= 16'd0;
          end else if (cycle_cnt == HOLD_LAST) begin
            cur_state <= RUN;
            cycle_cnt <= 16'd0;
            rst_out   <= 1'b0;
            ready     <= 1'b1;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        RUN: begin
          // Lock loss wins over a simultaneous soft reset.
          if (!locked_s) begin
            cur_state <= WAIT_LOCK;
            cycle_cnt <= 16'd0;
            rst_out   <= 1'b1;
            ready     <= 1'b0;
            if (lock_loss_cnt != 8'hFF) begin
              lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
          end else if (soft_reset) begin
            cur_state <= HOLD;
            cycle_cnt <= 16'd0;
            rst_out   <= 1'b1;
            ready     <= 1'b0;
          end
        end
        default: begin
          cur_state <= WAIT_LOCK;
          cycle_cnt <= 16'd0;
          rst_out   <= 1'b1;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  assign state = cur_state;

endmodule
